// File: rtl/deser_pkg.sv
// Shared definitions for the deserializer and related serial-path blocks.
package deser_pkg;

   localparam int unsigned DESER_WIDTH = 43;
   localparam int unsigned DESER_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter: clears on demand, counts accepted bits, flags the last bit.
module bit_counter #(
   parameter int unsigned WIDTH = 43,
   parameter int unsigned CNT_W = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic tc_c
);

   logic [CNT_W-1:0] count;

   // Terminal count: the next accepted bit completes the word.
   assign tc_c = (count == CNT_W'(WIDTH - 1));

   // Count accepted bits; wrap to zero on the final bit so no partial frame is carried over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= tc_c ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel converter with selectable bit order and a hold/handshake stage.
module deserializer
   import deser_pkg::*;
#(
   parameter int unsigned WIDTH = DESER_WIDTH,
   parameter int unsigned CNT_W = DESER_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             shift_switch,
   input  logic             serial_valid,
   input  logic             serial_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun
);

   state_t           state;
   logic             dir_q;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted_c;
   logic             restart_c;
   logic             accept_c;
   logic             cnt_tc_c;

   // A start begins a new frame from IDLE, aborts one in COLLECT, or chains after an accepted word.
   assign restart_c = start && ((state == IDLE) || (state == COLLECT) ||
                                ((state == HOLD) && out_ready));

   // A bit is taken only while collecting and not being aborted in the same cycle.
   assign accept_c  = (state == COLLECT) && serial_valid && !start;

   // Next shift-register contents for the latched bit order.
   assign shifted_c = dir_q ? {serial_in, shreg[WIDTH-1:1]}
                            : {shreg[WIDTH-2:0], serial_in};

   bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (restart_c),
      .inc   (accept_c),
      .tc_c  (cnt_tc_c)
   );

   // Frame FSM, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dir_q     <= 1'b0;
         shreg     <= '0;
         out_value <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  dir_q <= shift_switch;
                  shreg <= '0;
                  state <= COLLECT;
                  busy  <= 1'b1;
               end
            end
            COLLECT: begin
               if (start) begin
                  dir_q <= shift_switch;
                  shreg <= '0;
               end else if (serial_valid) begin
                  shreg <= shifted_c;
                  if (cnt_tc_c) begin
                     out_value <= shifted_c;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (serial_valid) begin
                  overrun <= 1'b1;
               end
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     dir_q <= shift_switch;
                     shreg <= '0;
                     state <= COLLECT;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for the deserializer: vector table plus hand-written corner sequences.
module tb_deserializer;

   localparam int unsigned W = 43;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         shift_switch;
   logic         serial_valid;
   logic         serial_in;
   logic         out_ready;
   logic [W-1:0] out_value;
   logic         out_valid;
   logic         busy;
   logic         overrun;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] sb[$];
   logic         prev_valid = 1'b0;

   typedef struct {
      logic         dir;
      bit           lsb_first;
      logic [W-1:0] word;
      bit           gaps;
      logic [W-1:0] expv;
   } vec_t;

   vec_t vecs[4];

   deserializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .shift_switch (shift_switch),
      .serial_valid (serial_valid),
      .serial_in    (serial_in),
      .out_ready    (out_ready),
      .out_value    (out_value),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: compare each newly presented word against the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && out_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_word", 64'(out_value), 64'hDEAD);
         end else begin
            check("sb_word", 64'(out_value), 64'(sb.pop_front()));
         end
      end
      prev_valid = rst_n && out_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic dir);
      start        = 1'b1;
      shift_switch = dir;
      step();
      start        = 1'b0;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input bit lsb_first,
                            input int first, input int n, input bit gaps);
      for (int i = first; i < first + n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               serial_valid = 1'b0;
               serial_in    = 1'($urandom_range(0, 1));
               step();
               check("bubble_valid", 64'(out_valid), 64'd0);
            end
         end
         serial_valid = 1'b1;
         serial_in    = lsb_first ? w[i] : w[W-1-i];
         step();
      end
      serial_valid = 1'b0;
   endtask

   // Full frame of W bits; checks the one-cycle latency after the last bit.
   task automatic run_frame(input logic dir, input bit lsb_first, input logic [W-1:0] w,
                            input bit gaps, input logic [W-1:0] expv, input bit do_start);
      sb.push_back(expv);
      if (do_start) start_frame(dir);
      send_bits(w, lsb_first, 0, W - 1, gaps);
      check("valid_before_last", 64'(out_valid), 64'd0);
      send_bits(w, lsb_first, W - 1, 1, 1'b0);
      check("valid_after_last", 64'(out_valid), 64'd1);
      check("busy_in_hold", 64'(busy), 64'd1);
      check("value_after_last", 64'(out_value), 64'(expv));
   endtask

   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] held;

      vecs[0] = '{dir: 1'b0, lsb_first: 1'b0, word: 43'h123_4567_89AB, gaps: 1'b0, expv: 43'h123_4567_89AB};
      vecs[1] = '{dir: 1'b1, lsb_first: 1'b1, word: 43'h123_4567_89AB, gaps: 1'b1, expv: 43'h123_4567_89AB};
      vecs[2] = '{dir: 1'b1, lsb_first: 1'b0, word: 43'h000_0000_0001, gaps: 1'b0, expv: 43'h400_0000_0000};
      vecs[3] = '{dir: 1'b0, lsb_first: 1'b1, word: 43'h7FF_FFFF_FFFE, gaps: 1'b1, expv: 43'h3FF_FFFF_FFFF};

      rst_n = 1'b0; start = 1'b0; shift_switch = 1'b0;
      serial_valid = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
      #12;
      check("rst_value", 64'(out_value), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      rst_n = 1'b1;
      step();

      // IDLE ignores serial bits and out_ready.
      serial_valid = 1'b1; serial_in = 1'b1; out_ready = 1'b1;
      step();
      check("idle_overrun", 64'(overrun), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      serial_valid = 1'b0; out_ready = 1'b0;

      // Vector table.
      for (int v = 0; v < 4; v++) begin
         run_frame(vecs[v].dir, vecs[v].lsb_first, vecs[v].word, vecs[v].gaps, vecs[v].expv, 1'b1);
         step();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_busy", 64'(busy), 64'd1);
         accept();
         check("accept_valid", 64'(out_valid), 64'd0);
         check("accept_busy", 64'(busy), 64'd0);
      end

      // Hold with injected bits: overrun pulses, word stable; start without ready ignored.
      run_frame(1'b0, 1'b0, 43'h2AA_AAAA_AAAA, 1'b0, 43'h2AA_AAAA_AAAA, 1'b1);
      held = out_value;
      for (int c = 0; c < 10; c++) begin
         serial_valid = (c == 2 || c == 5 || c == 8);
         serial_in    = 1'b1;
         start        = (c == 6);
         step();
         check("hold_overrun", 64'(overrun), 64'(c == 2 || c == 5 || c == 8));
         check("hold_value", 64'(out_value), 64'(held));
         check("hold_valid_stable", 64'(out_valid), 64'd1);
      end
      serial_valid = 1'b0; start = 1'b0;
      accept();
      check("ovr_accept_valid", 64'(out_valid), 64'd0);
      check("ovr_accept_busy", 64'(busy), 64'd0);
      check("ovr_accept_overrun", 64'(overrun), 64'd0);

      // Abort after 20 bits, restart with all ones.
      start_frame(1'b0);
      send_bits(43'h000_0000_0000, 1'b0, 0, 20, 1'b0);
      run_frame(1'b0, 1'b0, 43'h7FF_FFFF_FFFF, 1'b0, 43'h7FF_FFFF_FFFF, 1'b1);
      accept();

      // Abort with a bit on the start cycle; that bit must be discarded.
      start_frame(1'b1);
      send_bits(43'h7FF_FFFF_FFFF, 1'b0, 0, 20, 1'b0);
      start = 1'b1; shift_switch = 1'b0; serial_valid = 1'b1; serial_in = 1'b1;
      step();
      start = 1'b0; serial_valid = 1'b0;
      run_frame(1'b0, 1'b0, 43'h0AB_CDEF_0123, 1'b0, 43'h0AB_CDEF_0123, 1'b0);
      accept();

      // Asynchronous reset mid-frame, then bits without start.
      start_frame(1'b0);
      send_bits(43'h555_5555_5555, 1'b0, 0, 30, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_value", 64'(out_value), 64'd0);
      check("async_busy", 64'(busy), 64'd0);
      check("async_valid", 64'(out_valid), 64'd0);
      check("async_overrun", 64'(overrun), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 13; i++) begin
         serial_valid = 1'b1; serial_in = 1'(i & 1);
         step();
         check("post_rst_valid", 64'(out_valid), 64'd0);
         check("post_rst_busy", 64'(busy), 64'd0);
      end
      serial_valid = 1'b0;

      // Back-to-back frames: ready and start in the same HOLD cycle.
      run_frame(1'b0, 1'b0, 43'h135_7924_68AC, 1'b0, 43'h135_7924_68AC, 1'b1);
      out_ready = 1'b1; start = 1'b1; shift_switch = 1'b1;
      step();
      out_ready = 1'b0; start = 1'b0;
      check("chain_valid", 64'(out_valid), 64'd0);
      check("chain_busy", 64'(busy), 64'd1);
      run_frame(1'b1, 1'b1, 43'h123_4567_89AB, 1'b0, 43'h123_4567_89AB, 1'b0);
      accept();
      check("chain_done_busy", 64'(busy), 64'd0);

      step();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
